// File: rtl/sbinit_sb_tx_arbiter.sv
// Round-robin arbiter that shares the single sideband TX channel between the
// SBINIT sub-FSMs and other LTSM message sources. One requester owns the
// channel from grant to ack; the message is latched at grant and driven with
// a one-cycle valid pulse toward the sideband serializer.
//
// Handshake: a requester raises i_req_valid (level) with its message and holds
// it until it sees a one-cycle o_req_ack. The arbiter grants only while the
// serializer is idle (i_SB_Busy=0), pulses o_valid_sb for one cycle, waits for
// i_SB_Busy to rise (or times out) and then fall, then acks the requester.
module sbinit_sb_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SB_MSG_WIDTH = 4,
    parameter int BUSY_TIMEOUT = 8,
    localparam int PTR_W       = $clog2(NUM_REQ)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*SB_MSG_WIDTH-1:0] i_req_msg,
    input  logic                            i_SB_Busy,
    output logic [NUM_REQ-1:0]              o_req_ack,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic [SB_MSG_WIDTH-1:0]         o_encoded_SB_msg,
    output logic                            o_valid_sb,
    output logic                            o_busy_timeout,
    output logic                            o_arb_busy,
    output logic [1:0]                      o_dbg_state,
    output logic [PTR_W-1:0]                o_dbg_rr_ptr
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_IDLE = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]              state_q,   state_d;
    logic [PTR_W-1:0]        rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0]        win_q,     win_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [NUM_REQ-1:0]      grant_q,   grant_d;
    logic [NUM_REQ-1:0]      ack_q,     ack_d;
    logic [SB_MSG_WIDTH-1:0] msg_q,     msg_d;
    logic                    valid_q,   valid_d;
    logic                    timeout_q, timeout_d;

    logic [PTR_W:0]          cand;
    logic [PTR_W-1:0]        win_idx;
    logic                    win_found;
    logic [SB_MSG_WIDTH-1:0] win_msg;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_found && i_req_valid[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Select the winning requester's message slice.
    always_comb begin
        win_msg = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == PTR_W'(k)) begin
                win_msg = i_req_msg[k*SB_MSG_WIDTH +: SB_MSG_WIDTH];
            end
        end
    end

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        msg_d     = msg_q;
        valid_d   = 1'b0;
        ack_d     = '0;
        timeout_d = 1'b0;

        if (!i_en) begin
            // Abort without ack; rr_ptr and the last message are kept.
            state_d = S_IDLE;
            grant_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!i_SB_Busy && win_found) begin
                        grant_d = ONE_HOT0 << win_idx;
                        msg_d   = win_msg;
                        valid_d = 1'b1;
                        win_d   = win_idx;
                        cnt_d   = '0;
                        state_d = S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (i_SB_Busy) begin
                        state_d = S_WAIT_IDLE;
                    end else if (cnt_q == CNT_W'(BUSY_TIMEOUT-1)) begin
                        // Serializer never responded: treat as sent, no retry.
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!i_SB_Busy) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    ack_d    = ONE_HOT0 << win_q;
                    grant_d  = '0;
                    cnt_d    = '0;
                    rr_ptr_d = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + PTR_W'(1);
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            msg_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            msg_q     <= msg_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_req_ack        = ack_q;
    assign o_grant          = grant_q;
    assign o_encoded_SB_msg = msg_q;
    assign o_valid_sb       = valid_q;
    assign o_busy_timeout   = timeout_q;
    assign o_arb_busy       = (state_q != S_IDLE);
    assign o_dbg_state      = state_q;
    assign o_dbg_rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_sbinit_sb_tx_arbiter.sv
// Directed bench for sbinit_sb_tx_arbiter (NUM_REQ=4, W=4, BUSY_TIMEOUT=8).
// Inputs change 1 ns after a rising edge and outputs are sampled at that
// same point, so each step() observes the result of exactly one edge.
module tb_sbinit_sb_tx_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic [3:0]  i_req_valid;
    logic [15:0] i_req_msg;
    logic        i_SB_Busy;
    logic [3:0]  o_req_ack;
    logic [3:0]  o_grant;
    logic [3:0]  o_encoded_SB_msg;
    logic        o_valid_sb;
    logic        o_busy_timeout;
    logic        o_arb_busy;
    logic [1:0]  o_dbg_state;
    logic [1:0]  o_dbg_rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed view {valid, timeout, ack, grant, msg, arb_busy, state}.
    logic [16:0] obs;
    logic [16:0] exp_v;
    assign obs = {o_valid_sb, o_busy_timeout, o_req_ack, o_grant,
                  o_encoded_SB_msg, o_arb_busy, o_dbg_state};

    sbinit_sb_tx_arbiter #(
        .NUM_REQ(4), .SB_MSG_WIDTH(4), .BUSY_TIMEOUT(8)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .i_req_valid(i_req_valid), .i_req_msg(i_req_msg), .i_SB_Busy(i_SB_Busy),
        .o_req_ack(o_req_ack), .o_grant(o_grant), .o_encoded_SB_msg(o_encoded_SB_msg),
        .o_valid_sb(o_valid_sb), .o_busy_timeout(o_busy_timeout), .o_arb_busy(o_arb_busy),
        .o_dbg_state(o_dbg_state), .o_dbg_rr_ptr(o_dbg_rr_ptr)
    );

    // Clock generation.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [16:0] e(input logic v, input logic to, input logic [3:0] ack,
                                      input logic [3:0] gnt, input logic [3:0] msg,
                                      input logic ab, input logic [1:0] st);
        return {v, to, ack, gnt, msg, ab, st};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_en = 1'b0; i_req_valid = 4'b0; i_req_msg = 16'h0; i_SB_Busy = 1'b0;
        step(); step();
        exp_v = e(0,0,4'b0,4'b0,4'h0,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d expected 0", o_dbg_rr_ptr); end
        i_rst_n = 1'b1; i_en = 1'b1;
        step();
        exp_v = e(0,0,4'b0,4'b0,4'h0,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL idle_no_req: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_single();
        i_req_valid = 4'b0010; i_req_msg = 16'h0020;
        step();
        exp_v = e(1,0,4'b0,4'b0010,4'h2,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL single_grant: got %b expected %b", obs, exp_v); end
        step();
        exp_v = e(0,0,4'b0,4'b0010,4'h2,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL single_valid_one_cycle: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = e(0,0,4'b0,4'b0010,4'h2,1,2'd2); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL single_wait_idle_%0d: got %b expected %b", i, obs, exp_v); end
        end
        i_SB_Busy = 1'b0;
        step();
        exp_v = e(0,0,4'b0,4'b0010,4'h2,1,2'd3); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL single_done: got %b expected %b", obs, exp_v); end
        step();
        exp_v = e(0,0,4'b0010,4'b0,4'h2,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL single_ack: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL single_rr_ptr: got %0d expected 2", o_dbg_rr_ptr); end
        i_req_valid = 4'b0;
        step();
        exp_v = e(0,0,4'b0,4'b0,4'h2,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL single_ack_pulse_msg_hold: got %b expected %b", obs, exp_v); end
    endtask

    task automatic test_contention();
        i_rst_n = 1'b0; step(); i_rst_n = 1'b1;
        i_req_valid = 4'b0101; i_req_msg = 16'h0301;
        step();
        exp_v = e(1,0,4'b0,4'b0001,4'h1,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL cont_first_grant: got %b expected %b", obs, exp_v); end
        // Requester 0 withdraws and changes its message after grant: sent msg is latched.
        i_req_valid = 4'b0100; i_req_msg = 16'h030A; i_SB_Busy = 1'b1;
        step();
        exp_v = e(0,0,4'b0,4'b0001,4'h1,1,2'd2); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL cont_msg_latched: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b0;
        step();
        exp_v = e(0,0,4'b0,4'b0001,4'h1,1,2'd3); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL cont_first_done: got %b expected %b", obs, exp_v); end
        step();
        exp_v = e(0,0,4'b0001,4'b0,4'h1,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL cont_first_ack: got %b expected %b", obs, exp_v); end
        step();
        exp_v = e(1,0,4'b0,4'b0100,4'h3,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL cont_second_grant: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b1; step(); i_SB_Busy = 1'b0; step();
        exp_v = e(0,0,4'b0,4'b0100,4'h3,1,2'd3); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL cont_second_done: got %b expected %b", obs, exp_v); end
        step();
        exp_v = e(0,0,4'b0100,4'b0,4'h3,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL cont_second_ack: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL cont_rr_ptr: got %0d expected 3", o_dbg_rr_ptr); end
        i_req_valid = 4'b0;
    endtask

    task automatic test_rr_wrap();
        i_req_valid = 4'b1001; i_req_msg = 16'h5006;
        step();
        exp_v = e(1,0,4'b0,4'b1000,4'h5,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_grant3: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b1; step(); i_SB_Busy = 1'b0; step(); step();
        exp_v = e(0,0,4'b1000,4'b0,4'h5,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_ack3: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL wrap_rr_ptr0: got %0d expected 0", o_dbg_rr_ptr); end
        i_req_valid = 4'b0001;
        step();
        exp_v = e(1,0,4'b0,4'b0001,4'h6,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_grant0: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b1; step(); i_SB_Busy = 1'b0; step(); step();
        exp_v = e(0,0,4'b0001,4'b0,4'h6,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL wrap_ack0: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd1) begin n_fail++; $display("FAIL wrap_rr_ptr1: got %0d expected 1", o_dbg_rr_ptr); end
        i_req_valid = 4'b0;
    endtask

    task automatic test_timeout();
        i_req_valid = 4'b0100; i_req_msg = 16'h0900; i_SB_Busy = 1'b0;
        step();
        exp_v = e(1,0,4'b0,4'b0100,4'h9,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL to_grant: got %b expected %b", obs, exp_v); end
        for (int i = 1; i < 8; i++) begin
            step();
            exp_v = e(0,0,4'b0,4'b0100,4'h9,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL to_waiting_%0d: got %b expected %b", i, obs, exp_v); end
        end
        step();
        exp_v = e(0,1,4'b0,4'b0100,4'h9,1,2'd3); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL to_pulse: got %b expected %b", obs, exp_v); end
        step();
        exp_v = e(0,0,4'b0100,4'b0,4'h9,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL to_ack: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL to_rr_ptr: got %0d expected 3", o_dbg_rr_ptr); end
        i_req_valid = 4'b0;
    endtask

    task automatic test_en_drop();
        i_req_valid = 4'b0010; i_req_msg = 16'h0070;
        step();
        exp_v = e(1,0,4'b0,4'b0010,4'h7,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL en_grant: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b1;
        step();
        exp_v = e(0,0,4'b0,4'b0010,4'h7,1,2'd2); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL en_wait_idle: got %b expected %b", obs, exp_v); end
        i_en = 1'b0;
        step();
        exp_v = e(0,0,4'b0,4'b0,4'h7,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL en_abort: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b0;
        step();
        exp_v = e(0,0,4'b0,4'b0,4'h7,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL en_disabled_no_ack: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL en_rr_kept: got %0d expected 3", o_dbg_rr_ptr); end
        i_en = 1'b1;
        step();
        exp_v = e(1,0,4'b0,4'b0010,4'h7,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL en_resend: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b1; step(); i_SB_Busy = 1'b0; step(); step();
        exp_v = e(0,0,4'b0010,4'b0,4'h7,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL en_resend_ack: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL en_rr_ptr: got %0d expected 2", o_dbg_rr_ptr); end
        i_req_valid = 4'b0;
    endtask

    task automatic test_reset_mid();
        i_req_valid = 4'b0001; i_req_msg = 16'h000C;
        step();
        exp_v = e(1,0,4'b0,4'b0001,4'hC,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected %b", obs, exp_v); end
        i_rst_n = 1'b0;
        step();
        exp_v = e(0,0,4'b0,4'b0,4'h0,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL rst_mid_clear: got %b expected %b", obs, exp_v); end
        n_checks++; if (o_dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rst_mid_rr: got %0d expected 0", o_dbg_rr_ptr); end
        i_rst_n = 1'b1; i_SB_Busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = e(0,0,4'b0,4'b0,4'h0,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL busy_gate_%0d: got %b expected %b", i, obs, exp_v); end
        end
        i_SB_Busy = 1'b0;
        step();
        exp_v = e(1,0,4'b0,4'b0001,4'hC,1,2'd1); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL busy_gate_release: got %b expected %b", obs, exp_v); end
        i_SB_Busy = 1'b1; step(); i_SB_Busy = 1'b0; step(); step();
        exp_v = e(0,0,4'b0001,4'b0,4'hC,0,2'd0); n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL busy_gate_ack: got %b expected %b", obs, exp_v); end
        i_req_valid = 4'b0;
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rr_wrap();
        test_timeout();
        test_en_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sbinit_sb_tx_arbiter.md
Name: sbinit_sb_tx_arbiter

Overview:
Shares the single sideband transmit channel between the SBINIT sub-FSMs and other LTSM message sources. The TX-side and RX-side FSMs both present encoded messages, e.g. out-of-reset, done_req and done_resp. This block grants one requester at a time in round-robin order. It drives the encoded message plus a one-cycle valid pulse, tracks the sideband busy handshake, and acknowledges the requester once its message has been accepted. It sits between the SBINIT/LTSM state machines and the sideband serializer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SB_MSG_WIDTH, 4, encoded sideband message width
BUSY_TIMEOUT, 8, cycles to wait for i_SB_Busy to rise after a valid pulse before declaring timeout (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_en  in  1  arbiter enable; low forces IDLE
i_req_valid  in  NUM_REQ  per-requester message request (level; held until ack)
i_req_msg  in  NUM_REQ*SB_MSG_WIDTH  per-requester encoded message; slice k = [k*W +: W]
i_SB_Busy  in  1  sideband serializer busy
o_req_ack  out  NUM_REQ  one-cycle pulse to the granted requester when its message is accepted
o_grant  out  NUM_REQ  one-hot owner of the channel; held from grant to ack
o_encoded_SB_msg  out  SB_MSG_WIDTH  message to the sideband
o_valid_sb  out  1  one-cycle pulse qualifying o_encoded_SB_msg
o_busy_timeout  out  1  one-cycle pulse: busy never rose within BUSY_TIMEOUT
o_arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_rst_n=0 at posedge): state=IDLE, rr_ptr=0, timeout counter=0, and every output is 0, including o_encoded_SB_msg. A reset mid-transaction drops the transaction with no ack.
- States: IDLE, WAIT_BUSY, WAIT_IDLE, DONE.
- IDLE: transition at the posedge where i_en=1, i_SB_Busy=0 and |i_req_valid.
  - Winner = first set bit of i_req_valid, searching from rr_ptr upward modulo NUM_REQ.
  - Registered on that edge: o_grant=onehot(winner), o_encoded_SB_msg=i_req_msg[winner], o_valid_sb=1, counter=0, state -> WAIT_BUSY.
  - If i_SB_Busy=1, stay in IDLE with no grant.
- WAIT_BUSY: o_valid_sb=0, so valid is exactly one cycle. The counter increments each cycle.
  - i_SB_Busy=1 -> WAIT_IDLE.
  - Otherwise, when counter==BUSY_TIMEOUT-1 -> DONE, with o_busy_timeout=1 for that one transition cycle. The message is treated as sent; there is no retry.
- WAIT_IDLE: i_SB_Busy=0 -> DONE; otherwise hold. There is no timeout here.
- DONE: o_req_ack[winner]=1 for exactly one cycle, o_grant cleared, rr_ptr=(winner+1) mod NUM_REQ, state -> IDLE.
  - A new grant can occur no earlier than the edge after DONE.
- Minimum transaction time, grant edge to ack cycle: 3 cycles plus the busy duration. Sustained throughput is at most one message per 4+busy cycles.
- o_encoded_SB_msg holds its last value after ack until the next grant. The receiving side samples it as a level.
- The message is latched at grant. Changes to i_req_msg or deassertion of i_req_valid after grant do not alter the sent message, and the ack is still issued.
- i_en=0 in any state: next edge goes to IDLE, clears o_grant, o_valid_sb and the counter, and issues no ack. rr_ptr and o_encoded_SB_msg are kept.
- Simultaneous requests: exactly one grant; the others wait. Each requester is served within NUM_REQ transactions (round-robin fairness).
- i_SB_Busy already high in the same cycle as the o_valid_sb pulse: it is sampled in WAIT_BUSY on the next edge, which is normal.
- o_req_ack and o_valid_sb never assert in the same cycle.
- o_grant is zero or one-hot at all times.

Test Plan:
- Single request: req1 valid with msg=2, busy rises 1 cycle after valid and lasts 3 cycles.
  -> o_valid_sb pulse with msg 2, o_grant=0010, o_req_ack=0010 one cycle after busy falls, rr_ptr=2.
- Contention: req0 (msg 1) and req2 (msg 3) valid together, rr_ptr=0.
  -> 1 sent first, then 3. Acks are 0001 then 0100, grants never overlap.
- Round-robin wrap: rr_ptr=3, requests 3 and 0 pending.
  -> 3 served first, then 0, then rr_ptr=1.
- Busy timeout: BUSY_TIMEOUT=8, i_SB_Busy held 0.
  -> o_busy_timeout pulses exactly 8 cycles after o_valid_sb, followed by the ack and return to IDLE.
- Enable drop: i_en=0 while in WAIT_IDLE.
  -> IDLE next edge, no ack, o_grant=0. Re-enabling with the request still valid resends the same msg.
- Sync reset mid-transaction, plus busy-gated grant: reset in WAIT_BUSY clears all outputs next edge.
  -> With i_SB_Busy=1 held in IDLE, no grant occurs until busy falls.
